// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory port arbiter.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    localparam int M0 = 0;
    localparam int M1 = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: round-robin with a priority register, or m1-first fixed priority.
module arb_rr2
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic [1:0] i_owner,
    output logic [1:0] o_winner
);

    // 1 means m1 wins a tie, 0 means m0 wins a tie.
    logic r_prio;

    // After a served transaction the tie-break flips to the master that was not served.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prio <= 1'b1;
        end else if (i_update && FIXED_PRIO == 0) begin
            r_prio <= i_owner[M0];
        end
    end

    // Pick a one-hot winner from the current requests.
    always_comb begin
        o_winner = 2'b00;
        if (FIXED_PRIO != 0) begin
            if (i_req[M1])      o_winner = 2'b10;
            else if (i_req[M0]) o_winner = 2'b01;
        end else if (i_req == 2'b11) begin
            o_winner = r_prio ? 2'b10 : 2'b01;
        end else begin
            o_winner = i_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the icache (m0) and dcache (m1) controllers.
// Grant is registered; the owner's request is forwarded combinationally while
// BUSY, and every ack is followed by a forced RELEASE cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic [1:0]  w_req;
    logic [1:0]  w_winner;
    logic        w_update;
    logic [CW-1:0] r_wdog;
    logic [CW-1:0] w_wdog_inc;
    logic        r_timeout;

    function automatic logic [CW-1:0] wdog_sat_inc(input logic [CW-1:0] v);
        if (v == CW'(TIMEOUT)) return v;
        return v + CW'(1);
    endfunction

    assign w_req      = {m1_enable_i, m0_enable_i};
    assign w_wdog_inc = wdog_sat_inc(r_wdog);
    assign rd_data_o  = mem_data_i;
    assign grant_o    = r_grant;
    assign timeout_o  = r_timeout;

    arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_req    (w_req),
        .i_update (w_update),
        .i_owner  (r_grant),
        .o_winner (w_winner)
    );

    // State and owner registers; reset abandons any transaction at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next state, owner forwarding and ack routing.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_update     = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_winner;
                end
            end
            BUSY: begin
                if (r_grant[M1]) begin
                    mem_enable_o = m1_enable_i;
                    mem_write_o  = m1_write_i;
                    mem_addr_o   = m1_addr_i;
                    mem_data_o   = m1_data_i;
                    m1_ack_o     = mem_ack_i;
                end else if (r_grant[M0]) begin
                    mem_enable_o = m0_enable_i;
                    mem_write_o  = m0_write_i;
                    mem_addr_o   = m0_addr_i;
                    mem_data_o   = m0_data_i;
                    m0_ack_o     = mem_ack_i;
                end
                if (mem_ack_i) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = 2'b00;
                    w_update    = 1'b1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // Watchdog: counts un-acked BUSY cycles, saturates, and latches a sticky flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == IDLE) begin
            r_wdog <= '0;
        end else if (r_state == BUSY && !mem_ack_i && TIMEOUT != 0) begin
            r_wdog <= w_wdog_inc;
            if (w_wdog_inc == CW'(TIMEOUT)) r_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_mem_port_arbiter;

    localparam int DW = 256;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_en = 0, m0_wr = 0, m1_en = 0, m1_wr = 0, mem_ack = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_data = '0, m1_data = '0, mem_rdata = '0;

    logic          rr_a0, rr_a1, rr_men, rr_mwr, rr_to;
    logic [AW-1:0] rr_maddr;
    logic [DW-1:0] rr_mdata, rr_rd;
    logic [1:0]    rr_g;
    logic          fp_a0, fp_a1, fp_men, fp_mwr, fp_to;
    logic [AW-1:0] fp_maddr;
    logic [DW-1:0] fp_mdata, fp_rd;
    logic [1:0]    fp_g;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0), .TIMEOUT(TO)) dut_rr (
        .clk_i(clk), .rst_i(rst_n),
        .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_ack_o(rr_a0),
        .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_ack_o(rr_a1),
        .rd_data_o(rr_rd), .mem_enable_o(rr_men), .mem_write_o(rr_mwr), .mem_addr_o(rr_maddr),
        .mem_data_o(rr_mdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .grant_o(rr_g), .timeout_o(rr_to));

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
        .clk_i(clk), .rst_i(rst_n),
        .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_ack_o(fp_a0),
        .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_ack_o(fp_a1),
        .rd_data_o(fp_rd), .mem_enable_o(fp_men), .mem_write_o(fp_mwr), .mem_addr_o(fp_maddr),
        .mem_data_o(fp_mdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .grant_o(fp_g), .timeout_o(fp_to));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model per instance (0 = round-robin, 1 = fixed): owner is the served master
    // index or -1, cool marks the forced gap cycle after an ack.
    int owner[2] = '{-1, -1};
    bit cool[2]  = '{1'b0, 1'b0};
    bit prio1[2] = '{1'b1, 1'b1};
    int wc[2]    = '{0, 0};
    bit tf[2]    = '{1'b0, 1'b0};

    task automatic model_step(input int k);
        if (owner[k] >= 0) begin
            if (mem_ack) begin
                if (k == 0) prio1[k] = (owner[k] == 0);
                owner[k] = -1;
                cool[k]  = 1'b1;
            end else begin
                if (wc[k] < TO) wc[k]++;
                if (wc[k] >= TO) tf[k] = 1'b1;
            end
        end else if (cool[k]) begin
            cool[k] = 1'b0;
        end else if (m0_en || m1_en) begin
            if (k == 1 || !(m0_en && m1_en)) owner[k] = m1_en ? 1 : 0;
            else                             owner[k] = prio1[k] ? 1 : 0;
            wc[k] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                owner[k] = -1; cool[k] = 1'b0; prio1[k] = 1'b1; wc[k] = 0; tf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic cmp(input int k, input string tag, input logic [1:0] g, input logic men,
                       input logic mwr, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic a0, input logic a1, input logic [DW-1:0] rd, input logic to);
        logic [1:0]    eg;
        logic          emen, emwr, ea0, ea1;
        logic [AW-1:0] ema;
        logic [DW-1:0] emd;
        eg = 2'b00; emen = 1'b0; emwr = 1'b0; ea0 = 1'b0; ea1 = 1'b0; ema = '0; emd = '0;
        if (owner[k] == 0) begin
            eg = 2'b01; emen = m0_en; emwr = m0_wr; ema = m0_addr; emd = m0_data; ea0 = mem_ack;
        end else if (owner[k] == 1) begin
            eg = 2'b10; emen = m1_en; emwr = m1_wr; ema = m1_addr; emd = m1_data; ea1 = mem_ack;
        end
        chk({tag, ".grant"},   DW'(g),   DW'(eg));
        chk({tag, ".mem_en"},  DW'(men), DW'(emen));
        chk({tag, ".mem_wr"},  DW'(mwr), DW'(emwr));
        chk({tag, ".mem_adr"}, DW'(ma),  DW'(ema));
        chk({tag, ".mem_dat"}, md,       emd);
        chk({tag, ".ack0"},    DW'(a0),  DW'(ea0));
        chk({tag, ".ack1"},    DW'(a1),  DW'(ea1));
        chk({tag, ".rd_data"}, rd,       mem_rdata);
        chk({tag, ".timeout"}, DW'(to),  DW'(tf[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, "rr", rr_g, rr_men, rr_mwr, rr_maddr, rr_mdata, rr_a0, rr_a1, rr_rd, rr_to);
        cmp(1, "fp", fp_g, fp_men, fp_mwr, fp_maddr, fp_mdata, fp_a0, fp_a1, fp_rd, fp_to);
    end

    function automatic logic [DW-1:0] r256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {8{32'hA5A5_A5A5}};

        // Reset state
        #2;
        chk("rst.mem_en",  DW'(rr_men), '0);
        chk("rst.grant",   DW'(rr_g),   '0);
        chk("rst.timeout", DW'(rr_to),  '0);
        chk("rst.acks",    DW'({rr_a0, rr_a1, fp_a0, fp_a1}), '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single read by m1, acked in its 10th BUSY cycle
        m1_en = 1; m1_wr = 0; m1_addr = 32'h0000_0400; m1_data = r256();
        neg(); chk("rd.en_before", DW'(rr_men), '0);
        cyc(); neg();
        chk("rd.mem_en", DW'(rr_men), DW'(1));
        chk("rd.addr",   DW'(rr_maddr), DW'(32'h400));
        chk("rd.write",  DW'(rr_mwr), '0);
        chk("rd.grant",  DW'(rr_g), DW'(2'b10));
        repeat (9) cyc();
        mem_ack = 1; mem_rdata = a5;
        neg();
        chk("rd.m1_ack", DW'(rr_a1), DW'(1));
        chk("rd.m0_ack", DW'(rr_a0), '0);
        chk("rd.data",   rr_rd, a5);
        cyc(); mem_ack = 0; m1_en = 0;
        neg();
        chk("rd.rel_grant", DW'(rr_g), '0);
        chk("rd.rel_en",    DW'(rr_men), '0);
        chk("rd.ack_once",  DW'(rr_a1), '0);
        cyc(); cyc();

        // Simultaneous requests after reset: m1 first, then m0
        rst_pulse();
        m0_en = 1; m0_wr = 0; m0_addr = 32'h100; m1_en = 1; m1_wr = 0; m1_addr = 32'h200;
        neg(); chk("sim.g0", DW'(rr_g), '0);
        cyc(); mem_ack = 1;
        neg();
        chk("sim.g1",   DW'(rr_g), DW'(2'b10));
        chk("sim.ack1", DW'(rr_a1), DW'(1));
        chk("sim.ack0", DW'(rr_a0), '0);
        chk("sim.adr1", DW'(rr_maddr), DW'(32'h200));
        cyc(); mem_ack = 0; m1_en = 0;
        neg(); chk("sim.g2", DW'(rr_g), '0);
        cyc(); neg(); chk("sim.g3", DW'(rr_g), '0);
        cyc(); mem_ack = 1;
        neg();
        chk("sim.g4",    DW'(rr_g), DW'(2'b01));
        chk("sim.adr0",  DW'(rr_maddr), DW'(32'h100));
        chk("sim.m0ack", DW'(rr_a0), DW'(1));
        chk("sim.fp_g4", DW'(fp_g), DW'(2'b01));
        cyc(); mem_ack = 0; m0_en = 0;
        cyc(); cyc();

        // Write-back then refill from m1 while m0 also requests
        rst_pulse();
        m1_en = 1; m1_wr = 1; m1_addr = 32'h800; m1_data = r256();
        cyc(); mem_ack = 1; m0_en = 1; m0_wr = 0; m0_addr = 32'h1000;
        neg();
        chk("b2b.wb_grant", DW'(rr_g), DW'(2'b10));
        chk("b2b.wb_write", DW'(rr_mwr), DW'(1));
        chk("b2b.wb_addr",  DW'(rr_maddr), DW'(32'h800));
        chk("b2b.wb_data",  rr_mdata, m1_data);
        cyc(); mem_ack = 0; m1_wr = 0; m1_addr = 32'h0C00;
        neg();
        chk("b2b.rel_en_rr", DW'(rr_men), '0);
        chk("b2b.rel_en_fp", DW'(fp_men), '0);
        cyc(); neg();
        chk("b2b.idle_rr", DW'(rr_g), '0);
        chk("b2b.idle_fp", DW'(fp_g), '0);
        cyc(); mem_ack = 1;
        neg();
        chk("b2b.rr_grant", DW'(rr_g), DW'(2'b01));
        chk("b2b.rr_addr",  DW'(rr_maddr), DW'(32'h1000));
        chk("b2b.fp_grant", DW'(fp_g), DW'(2'b10));
        chk("b2b.fp_addr",  DW'(fp_maddr), DW'(32'hC00));
        cyc(); mem_ack = 0; m0_en = 0;
        cyc(); cyc();
        neg();
        chk("b2b.rr_refill", DW'(rr_g), DW'(2'b10));
        chk("b2b.rr_radr",   DW'(rr_maddr), DW'(32'hC00));
        cyc(); mem_ack = 1;
        cyc(); mem_ack = 0; m1_en = 0;
        cyc(); cyc(); cyc();

        // Stray acks in IDLE and in RELEASE
        mem_ack = 1;
        neg();
        chk("stray.idle_acks", DW'({rr_a0, rr_a1, fp_a0, fp_a1}), '0);
        chk("stray.idle_g",    DW'(rr_g), '0);
        cyc(); mem_ack = 0;
        neg(); chk("stray.idle_after", DW'({rr_g, rr_men}), '0);
        cyc(); m0_en = 1; m0_addr = 32'h40;
        cyc(); mem_ack = 1;
        neg(); chk("stray.real_ack", DW'(rr_a0), DW'(1));
        cyc(); m0_en = 0;
        neg();
        chk("stray.rel_acks", DW'({rr_a0, rr_a1, fp_a0, fp_a1}), '0);
        chk("stray.rel_g",    DW'(rr_g), '0);
        cyc(); mem_ack = 0;
        neg(); chk("stray.idle2", DW'({rr_g, rr_men}), '0);
        cyc(); neg(); chk("stray.idle3", DW'(rr_g), '0);

        // Watchdog, then asynchronous reset mid-BUSY
        rst_pulse();
        m0_en = 1; m0_addr = 32'h2000;
        cyc();
        for (int i = 1; i <= TO; i++) begin
            neg(); chk("wd.low", DW'(rr_to), '0);
            cyc();
        end
        neg();
        chk("wd.rise_rr", DW'(rr_to), DW'(1));
        chk("wd.rise_fp", DW'(fp_to), DW'(1));
        repeat (3) begin
            cyc(); neg();
            chk("wd.sticky", DW'(rr_to), DW'(1));
            chk("wd.still_busy", DW'(rr_men), DW'(1));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("wd.arst_en_rr", DW'(rr_men), '0);
        chk("wd.arst_en_fp", DW'(fp_men), '0);
        chk("wd.arst_g",     DW'(rr_g), '0);
        chk("wd.arst_to",    DW'(rr_to), '0);
        m0_en = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the model
        repeat (3000) begin
            cyc();
            m0_en     = ($urandom_range(0, 3) != 0);
            m1_en     = ($urandom_range(0, 3) != 0);
            m0_wr     = $urandom_range(0, 1) == 1;
            m1_wr     = $urandom_range(0, 1) == 1;
            m0_addr   = $urandom;
            m1_addr   = $urandom;
            m0_data   = r256();
            m1_data   = r256();
            mem_rdata = r256();
            mem_ack   = ($urandom_range(0, 4) == 0);
        end
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
